// File: rtl/compound_accumulator.sv
// compound_accumulator
//
// Consumes {x, y} word pairs from an upstream producer, buffers them in a
// small FIFO, folds x + y into a running 32-bit total and presents the total
// plus a saturating sample count to the next stage.
//
// Ports
//   clk           single clock, all state on posedge
//   rst           synchronous active-low reset
//   m_in          {x[31:0], y[31:0]} from the producer
//   m_in_sync     producer has valid data
//   m_in_notify   ready to accept m_in (registered, reflects post-update occupancy)
//   s_out         accumulated total
//   s_count       number of samples folded into s_out (saturates at 16'hFFFF)
//   s_out_sync    downstream ready
//   s_out_notify  s_out / s_count valid
//
// Parameters
//   DEPTH         input FIFO entries, power of two, >= 2
//   ACC_INIT      accumulator value loaded at reset

module compound_accumulator #(
   parameter int unsigned DEPTH    = 2,
   parameter logic [31:0] ACC_INIT = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] m_in,
   input  logic        m_in_sync,
   output logic        m_in_notify,
   output logic [31:0] s_out,
   output logic [15:0] s_count,
   input  logic        s_out_sync,
   output logic        s_out_notify
);

   localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // One extra pointer bit separates the full and empty cases.
   localparam int unsigned PtrW  = AddrW + 1;

   typedef enum logic [0:0] {
      StRead,
      StWrite
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e            state_q, state_d;
   logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
   logic              ready_q, ready_d;
   logic [31:0]       acc_q, acc_d;
   logic [15:0]       count_q, count_d;
   logic [63:0]       mem_q [DEPTH];

   // ---------------------------------------------------------------------------
   // FIFO status and handshakes
   // ---------------------------------------------------------------------------
   logic              fifo_empty;
   logic              full_next;
   logic              push;
   logic              pop;
   logic [63:0]       head;
   logic [31:0]       head_x;
   logic [31:0]       head_y;

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);

   // Acceptance is gated by the registered ready only, so a pop in the same
   // cycle never opens the input combinationally.
   assign push = m_in_sync && ready_q;

   // Pop decisions look at the current occupancy; data pushed this cycle is
   // not visible until the next one (no bypass).
   assign pop = (state_q == StRead) && !fifo_empty;

   assign head   = mem_q[rd_ptr_q[AddrW-1:0]];
   assign head_x = head[63:32];
   assign head_y = head[31:0];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PtrW'(push);
      rd_ptr_d = rd_ptr_q + PtrW'(pop);
   end

   assign full_next = (wr_ptr_d[AddrW] != rd_ptr_d[AddrW]) &&
                      (wr_ptr_d[AddrW-1:0] == rd_ptr_d[AddrW-1:0]);

   assign ready_d = !full_next;

   // ---------------------------------------------------------------------------
   // Section FSM and datapath next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      count_d = count_q;

      unique case (state_q)
         StRead: begin
            if (pop) begin
               // 32-bit wraparound sum; carries out of bit 31 are dropped.
               acc_d   = acc_q + head_x + head_y;
               count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
               state_d = StWrite;
            end
         end
         StWrite: begin
            if (s_out_sync) begin
               state_d = StRead;
            end
         end
         default: begin
            state_d = StRead;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StRead;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ready_q  <= 1'b1;
         acc_q    <= ACC_INIT;
         count_q  <= 16'h0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ready_q  <= ready_d;
         acc_q    <= acc_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the pointers alone define which entries are live.
   always_ff @(posedge clk) begin
      if (rst && push) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= m_in;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign m_in_notify  = ready_q;
   assign s_out_notify = (state_q == StWrite);
   assign s_out        = acc_q;
   assign s_count      = count_q;

endmodule

// File: tb/tb_compound_accumulator.sv
module tb_compound_accumulator;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] m_in;
   logic        m_in_sync;
   logic        m_in_notify;
   logic [31:0] s_out;
   logic [15:0] s_count;
   logic        s_out_sync;
   logic        s_out_notify;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   compound_accumulator #(
      .DEPTH   (2),
      .ACC_INIT(32'h0)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .m_in        (m_in),
      .m_in_sync   (m_in_sync),
      .m_in_notify (m_in_notify),
      .s_out       (s_out),
      .s_count     (s_count),
      .s_out_sync  (s_out_sync),
      .s_out_notify(s_out_notify)
   );

   typedef struct {
      logic        rst;
      logic [63:0] m_in;
      logic        m_sync;
      logic        o_sync;
      logic        e_mnot;
      logic        e_snot;
      logic [31:0] e_out;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic mnot, input logic snot,
                             input logic [31:0] out, input logic [15:0] cnt);
      check({tag, ".m_in_notify"}, 64'(m_in_notify), 64'(mnot));
      check({tag, ".s_out_notify"}, 64'(s_out_notify), 64'(snot));
      check({tag, ".s_out"}, 64'(s_out), 64'(out));
      check({tag, ".s_count"}, 64'(s_count), 64'(cnt));
   endtask

   // Drive inputs on the falling edge, let the rising edge act, sample on the
   // next falling edge.
   task automatic step(input logic r, input logic [63:0] d, input logic ms, input logic os);
      rst        = r;
      m_in       = d;
      m_in_sync  = ms;
      s_out_sync = os;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic logic [63:0] w(input logic [31:0] x, input logic [31:0] y);
      return {x, y};
   endfunction

   // Reference model state for the streaming run
   logic [31:0] ref_sum;
   int          ref_cnt;
   logic [31:0] exp_sum_q[$];
   logic [15:0] exp_cnt_q[$];

   initial begin
      rst        = 1'b0;
      m_in       = '0;
      m_in_sync  = 1'b0;
      s_out_sync = 1'b0;

      // Columns: rst, m_in, m_sync, o_sync | m_in_notify, s_out_notify, s_out, s_count
      // Reset held for two clocks
      vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0});
      vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0});
      // Single {5,7}: valid two cycles after the push
      vecs.push_back('{1'b1, w(5, 7), 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 16'd0});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd12, 16'd1});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd12, 16'd1});
      // Wraparound: {FFFFFFFF,2} then {0,3}
      vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0});
      vecs.push_back('{1'b1, w(32'hFFFF_FFFF, 2), 1'b1, 1'b1, 1'b1, 1'b0, 32'd0, 16'd0});
      vecs.push_back('{1'b1, w(0, 3), 1'b1, 1'b1, 1'b1, 1'b1, 32'd1, 16'd1});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd1, 16'd1});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd4, 16'd2});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd4, 16'd2});
      // Backpressure: three words with downstream stalled, fourth held off
      vecs.push_back('{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0});
      vecs.push_back('{1'b1, w(1, 2), 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0});
      vecs.push_back('{1'b1, w(3, 4), 1'b1, 1'b0, 1'b1, 1'b1, 32'd3, 16'd1});
      vecs.push_back('{1'b1, w(5, 6), 1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1});
      vecs.push_back('{1'b1, w(100, 200), 1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1});
      vecs.push_back('{1'b1, w(700, 800), 1'b1, 1'b0, 1'b0, 1'b1, 32'd3, 16'd1});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd3, 16'd1});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd10, 16'd2});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd10, 16'd2});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd21, 16'd3});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd21, 16'd3});
      vecs.push_back('{1'b1, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd21, 16'd3});

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].m_in, vecs[i].m_sync, vecs[i].o_sync);
         check_outs($sformatf("vec%0d", i), vecs[i].e_mnot, vecs[i].e_snot,
                    vecs[i].e_out, vecs[i].e_cnt);
      end

      // Reset in the middle of operation: FIFO full and output pending
      step(1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b1, w(9, 9), 1'b1, 1'b0);
      step(1'b1, w(8, 8), 1'b1, 1'b0);
      step(1'b1, w(7, 7), 1'b1, 1'b0);
      check("midrst.pre_full", 64'(m_in_notify), 64'd0);
      check("midrst.pre_valid", 64'(s_out_notify), 64'd1);
      step(1'b0, 64'h0, 1'b0, 1'b0);
      check_outs("midrst.after", 1'b1, 1'b0, 32'd0, 16'd0);
      step(1'b1, w(1, 1), 1'b1, 1'b1);
      step(1'b1, 64'h0, 1'b0, 1'b1);
      check_outs("midrst.push11", 1'b1, 1'b1, 32'd2, 16'd1);
      // Discarded entries must never surface
      step(1'b1, 64'h0, 1'b0, 1'b1);
      step(1'b1, 64'h0, 1'b0, 1'b1);
      check_outs("midrst.drained", 1'b1, 1'b0, 32'd2, 16'd1);

      // Streaming: 100 random words with random producer and consumer stalls
      step(1'b0, 64'h0, 1'b0, 1'b0);
      rst = 1'b1;
      ref_sum = 32'h0;
      ref_cnt = 0;
      begin
         int n_push = 0;
         int n_seen = 0;
         int budget = 5000;
         while ((n_seen < 100) && (budget > 0)) begin
            budget--;
            m_in       = {$urandom(), $urandom()};
            m_in_sync  = (n_push < 100) && ($urandom_range(0, 3) != 0);
            s_out_sync = ($urandom_range(0, 3) != 0);
            if (s_out_notify && s_out_sync) begin
               if (exp_sum_q.size() == 0) begin
                  check("stream.unexpected_output", 64'(s_count), 64'hFFFF_FFFF);
               end else begin
                  check($sformatf("stream.out%0d", n_seen),
                        {16'h0, s_count, s_out}, {16'h0, exp_cnt_q[0], exp_sum_q[0]});
                  void'(exp_sum_q.pop_front());
                  void'(exp_cnt_q.pop_front());
               end
               n_seen++;
            end
            if (m_in_sync && m_in_notify) begin
               ref_sum = ref_sum + m_in[63:32] + m_in[31:0];
               ref_cnt++;
               exp_sum_q.push_back(ref_sum);
               exp_cnt_q.push_back(16'(ref_cnt));
               n_push++;
            end
            @(posedge clk);
            @(negedge clk);
         end
         if (budget == 0) begin
            check("stream.timeout", 64'(n_seen), 64'd100);
         end
      end
      m_in_sync  = 1'b0;
      s_out_sync = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("stream.final_sum", 64'(s_out), 64'(ref_sum));
      check("stream.final_count", 64'(s_count), 64'd100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
